// File: rtl/game_pkg.sv
// game_pkg: shared types and screen codes for the game sequencer.
//   game_state_t : sequencer FSM states
//   SCR_*        : 6-bit screen codes understood by the matrix display modules
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT3,
    S_CNT2,
    S_CNT1,
    S_GO,
    S_PLAY,
    S_WIN
  } game_state_t;

  localparam logic [5:0] SCR_IDLE    = 6'd0;
  localparam logic [5:0] SCR_GO      = 6'd31;
  localparam logic [5:0] SCR_ONE     = 6'd32;
  localparam logic [5:0] SCR_TWO     = 6'd33;
  localparam logic [5:0] SCR_THREE   = 6'd34;
  localparam logic [5:0] SCR_P1WIN   = 6'd16;
  localparam logic [5:0] SCR_P2WIN   = 6'd30;
  localparam logic [5:0] MULTI_START = 6'd23;
  localparam logic [5:0] SINGLE_WIN  = 6'd14;

endpackage

// File: rtl/game_if.sv
// game_if: player/control inputs and display-side outputs of the sequencer.
//   master : stimulus side (drives start, mode, presses; reads screen/status)
//   slave  : sequencer side
interface game_if;
  logic       start;
  logic       mode_multi;
  logic       p1_press;
  logic       p2_press;
  logic [5:0] screen;
  logic       multi_sel;
  logic       busy;
  logic       game_over;

  modport master (
    output start, mode_multi, p1_press, p2_press,
    input  screen, multi_sel, busy, game_over
  );

  modport slave (
    input  start, mode_multi, p1_press, p2_press,
    output screen, multi_sel, busy, game_over
  );
endinterface

// File: rtl/game_sequencer_phase_timer.sv
// phase_timer: clearable up-counter with a terminal-count flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : force count to 0 (takes priority)
//   limit      : period in cycles; count runs 0..limit-1 then wraps
//   tc         : high while count == limit-1
module phase_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  assign tc = (count == limit - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clr)    count <= '0;
    else if (tc)     count <= '0;  // wrap lets PLAY reuse it as a periodic decay tick
    else             count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: countdown / play / win controller for the matrix display.
//   clk, reset : clock, async active-low reset
//   bus        : game_if.slave
//     start, mode_multi, p1_press, p2_press : one-cycle debounced inputs
//     screen    : registered 6-bit screen code
//     multi_sel : registered accepted mode (1 = tug-of-war display)
//     busy      : high outside IDLE
//     game_over : one-cycle pulse on entry to WIN
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 10_000_000,
  parameter int unsigned DECAY_CYCLES = 5_000_000,
  parameter int unsigned WIN_HOLD     = 40_000_000,
  parameter int unsigned CNT_W        = 32
) (
  input logic   clk,
  input logic   reset,
  game_if.slave bus
);

  localparam logic [CNT_W-1:0] TICK_L  = CNT_W'(TICK_CYCLES);
  localparam logic [CNT_W-1:0] DECAY_L = CNT_W'(DECAY_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(WIN_HOLD);

  game_state_t state, state_nx;
  logic [5:0]  pos, pos_nx;
  logic [5:0]  screen, screen_nx;
  logic        msel, msel_nx;
  logic        busy, game_over;

  logic             tmr_clr, tmr_tc;
  logic [CNT_W-1:0] tmr_limit;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  // One timer serves every phase; its period follows the current state.
  always_comb begin
    tmr_limit = TICK_L;
    case (state)
      S_PLAY:  tmr_limit = DECAY_L;
      S_WIN:   tmr_limit = HOLD_L;
      default: tmr_limit = TICK_L;
    endcase
  end

  // Held at zero in IDLE and restarted on every state change.
  assign tmr_clr = (state_nx != state) || (state == S_IDLE);

  always_comb begin
    state_nx  = state;
    pos_nx    = pos;
    screen_nx = screen;
    msel_nx   = msel;
    case (state)
      S_IDLE: begin
        screen_nx = SCR_IDLE;
        if (bus.start) begin
          msel_nx   = bus.mode_multi;
          state_nx  = S_CNT3;
          screen_nx = SCR_THREE;
        end
      end
      S_CNT3: if (tmr_tc) begin state_nx = S_CNT2; screen_nx = SCR_TWO; end
      S_CNT2: if (tmr_tc) begin state_nx = S_CNT1; screen_nx = SCR_ONE; end
      S_CNT1: if (tmr_tc) begin state_nx = S_GO;   screen_nx = SCR_GO;  end
      S_GO: begin
        if (tmr_tc) begin
          state_nx  = S_PLAY;
          pos_nx    = msel ? MULTI_START : 6'd0;
          screen_nx = pos_nx;
        end
      end
      S_PLAY: begin
        if (msel) begin
          if (bus.p1_press && !bus.p2_press)      pos_nx = pos - 6'd1;
          else if (bus.p2_press && !bus.p1_press) pos_nx = pos + 6'd1;
          if (pos_nx == SCR_P1WIN || pos_nx == SCR_P2WIN) state_nx = S_WIN;
        end else begin
          // Timer terminal count is the decay event; a press cancels it.
          if (bus.p1_press && !tmr_tc)                     pos_nx = pos + 6'd1;
          else if (tmr_tc && !bus.p1_press && pos != 6'd0) pos_nx = pos - 6'd1;
          if (pos_nx == SINGLE_WIN) state_nx = S_WIN;
        end
        screen_nx = pos_nx;
      end
      S_WIN: if (tmr_tc) begin state_nx = S_IDLE; screen_nx = SCR_IDLE; end
      default: begin
        state_nx  = S_IDLE;
        screen_nx = SCR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pos       <= '0;
      screen    <= '0;
      msel      <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      pos       <= pos_nx;
      screen    <= screen_nx;
      msel      <= msel_nx;
      busy      <= (state_nx != S_IDLE);
      game_over <= (state == S_PLAY) && (state_nx == S_WIN);
    end
  end

  assign bus.screen    = screen;
  assign bus.multi_sel = msel;
  assign bus.busy      = busy;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer with short timings
// (TICK=4, DECAY=8, WIN_HOLD=6). Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_pos;
  logic pr, dc;

  game_if bus();

  game_sequencer #(
    .TICK_CYCLES  (4),
    .DECAY_CYCLES (8),
    .WIN_HOLD     (6),
    .CNT_W        (32)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.start = 0; bus.mode_multi = 0; bus.p1_press = 0; bus.p2_press = 0;

    // 1: reset and idle
    tick(3);
    chk("rst_screen", bus.screen, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_msel", bus.multi_sel, 0);
    chk("rst_gover", bus.game_over, 0);
    rst_n = 1;
    tick(5);
    chk("idle_screen", bus.screen, 0);
    chk("idle_busy", bus.busy, 0);

    // 2: multi countdown, presses ignored
    bus.mode_multi = 1; bus.start = 1; tick(1); bus.start = 0;
    chk("cd3_first", bus.screen, 34);
    chk("cd_busy", bus.busy, 1);
    chk("cd_msel", bus.multi_sel, 1);
    bus.p1_press = 1; tick(1); bus.p1_press = 0;
    tick(2);
    chk("cd3_last", bus.screen, 34);
    tick(1);
    chk("cd2", bus.screen, 33);
    tick(3); bus.p1_press = 1; tick(1); bus.p1_press = 0;
    chk("cd1", bus.screen, 32);
    tick(4);
    chk("cdgo", bus.screen, 31);
    tick(3); bus.p1_press = 1; tick(1); bus.p1_press = 0;
    chk("multi_start", bus.screen, 23);

    // 3: P1 walks the barrier to 16
    for (int i = 0; i < 6; i++) begin
      bus.p1_press = 1; tick(1); bus.p1_press = 0;
      chk("p1_step", bus.screen, 22 - i);
    end
    bus.p1_press = 1; tick(1); bus.p1_press = 0;
    chk("p1_win_scr", bus.screen, 16);
    chk("p1_win_gover", bus.game_over, 1);
    tick(1);
    chk("gover_pulse", bus.game_over, 0);
    tick(4);
    chk("win_hold_end", bus.screen, 16);
    chk("win_busy", bus.busy, 1);
    tick(1);
    chk("win_to_idle", bus.screen, 0);
    chk("idle_busy2", bus.busy, 0);
    chk("msel_kept", bus.multi_sel, 1);

    // 4: P2 reaches 30, simultaneous presses cancel
    bus.mode_multi = 1; bus.start = 1; tick(1); bus.start = 0;
    tick(16);
    chk("multi_start2", bus.screen, 23);
    for (int i = 0; i < 6; i++) begin
      bus.p2_press = 1; tick(1); bus.p2_press = 0;
      chk("p2_step", bus.screen, 24 + i);
    end
    bus.p1_press = 1; bus.p2_press = 1; tick(1); bus.p1_press = 0; bus.p2_press = 0;
    chk("both_cancel", bus.screen, 29);
    bus.p2_press = 1; tick(1); bus.p2_press = 0;
    chk("p2_win_scr", bus.screen, 30);
    chk("p2_win_gover", bus.game_over, 1);
    // start during WIN is ignored
    bus.mode_multi = 0; bus.start = 1; tick(1); bus.start = 0;
    chk("win_start_scr", bus.screen, 30);
    chk("win_start_msel", bus.multi_sel, 1);
    tick(4);
    chk("p2_hold_end", bus.screen, 30);
    tick(1);
    chk("p2_to_idle", bus.screen, 0);
    tick(2);
    chk("no_restart_busy", bus.busy, 0);
    chk("no_restart_scr", bus.screen, 0);

    // 5: single player with decay every 8 cycles in PLAY
    bus.mode_multi = 0; bus.start = 1; tick(1); bus.start = 0;
    chk("single_msel", bus.multi_sel, 0);
    chk("single_cd3", bus.screen, 34);
    tick(16);
    chk("single_start", bus.screen, 0);
    exp_pos = 0;
    for (int e = 1; e <= 60; e++) begin
      pr = (((e >= 12) && (e <= 20)) || (e >= 26)) && (e % 2 == 0);
      bus.p1_press = pr;
      bus.p2_press = (e % 2 == 1);
      tick(1);
      bus.p1_press = 0; bus.p2_press = 0;
      dc = (e % 8 == 0);
      if (pr && !dc) exp_pos++;
      else if (dc && !pr && exp_pos > 0) exp_pos--;
      chk("single_pos", bus.screen, exp_pos);
      if (exp_pos == 14) break;
    end
    chk("single_win_gover", bus.game_over, 1);
    tick(5);
    chk("single_hold", bus.screen, 14);
    tick(1);
    chk("single_to_idle", bus.screen, 0);

    // 6: reset in the middle of PLAY
    bus.mode_multi = 1; bus.start = 1; tick(1); bus.start = 0;
    tick(16);
    bus.p2_press = 1; tick(1); bus.p2_press = 0;
    chk("pre_reset_pos", bus.screen, 24);
    rst_n = 0; #1;
    chk("midrst_scr", bus.screen, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_msel", bus.multi_sel, 0);
    tick(2);
    rst_n = 1;
    tick(3);
    chk("post_rst_scr", bus.screen, 0);
    bus.mode_multi = 0; bus.start = 1; tick(1); bus.start = 0;
    chk("post_rst_start", bus.screen, 34);
    chk("post_rst_busy", bus.busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
